// File: rtl/maxnet_scheduler_pkg.sv
// Shared definitions for the MaxNet datapath controllers.
// The single-client controller and its bench use the same state encodings,
// so keep these values stable.
package maxnet_scheduler_pkg;

    // Sequencer states. Encodings are fixed 3-bit values.
    // Code 3'd7 is unused, and the FSM treats it as a return to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MULT  = 3'd2,
        ADD   = 3'd3,
        WB    = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/maxnet_scheduler_if.sv
// Bundle of the requester/datapath signals around the scheduler.
// The master side is the clients plus the datapath, and the slave side is the scheduler.
interface maxnet_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int ITER_W = 5
) ();

    logic [N_REQ-1:0]  req;
    logic              is_finished;
    logic [N_REQ-1:0]  grant;
    logic              init_w;
    logic              init_x;
    logic              load_a;
    logic              load_sel;
    logic              busy;
    logic [N_REQ-1:0]  done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output req, is_finished,
        input  grant, init_w, init_x, load_a, load_sel, busy, done, timeout, iter_count
    );

    modport slave (
        input  req, is_finished,
        output grant, init_w, init_x, load_a, load_sel, busy, done, timeout, iter_count
    );

endinterface

// File: rtl/maxnet_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// It scans upward from the pointer, wraps modulo N_REQ, and returns the first
// asserted request as a one-hot vector together with its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_cand;
    int               candIdx;

    // Walk the requesters in priority order starting at the pointer.
    // The first hit wins and later hits are masked.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        candIdx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            candIdx = int'(i_ptr) + i;
            if (candIdx >= N_REQ) begin
                candIdx = candIdx - N_REQ;
            end
            w_cand = PTR_W'(candIdx);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/maxnet_scheduler.sv
// Round-robin scheduler that shares one MaxNet iteration datapath between
// N_REQ requesters.
// Each job runs INIT once, then MULT/ADD/WB/CHECK rounds until the datapath
// converges or the round cap forces completion.
module maxnet_scheduler
    import maxnet_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    maxnet_scheduler_if.slave   bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_grantIdx;
    logic [PTR_W-1:0]   r_ptr;
    logic [ITER_W-1:0]  r_iter;
    logic               r_timeout;
    logic               r_initW;
    logic               r_initX;
    logic               r_loadA;
    logic               r_loadSel;
    logic               r_busy;
    logic [N_REQ-1:0]   r_done;

    logic [N_REQ-1:0]   w_winner;
    logic [PTR_W-1:0]   w_winnerIdx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_winner),
        .o_idx   (w_winnerIdx)
    );

    // Sequencer, iteration counter, flags and registered strobes.
    // Each strobe is loaded together with the state it belongs to, so the
    // outputs line up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_ptr      <= '0;
            r_iter     <= '0;
            r_timeout  <= 1'b0;
            r_initW    <= 1'b0;
            r_initX    <= 1'b0;
            r_loadA    <= 1'b0;
            r_loadSel  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= '0;
        end else begin
            r_initW   <= 1'b0;
            r_initX   <= 1'b0;
            r_loadA   <= 1'b0;
            r_loadSel <= 1'b0;
            r_done    <= '0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state    <= INIT;
                        r_grant    <= w_winner;
                        r_grantIdx <= w_winnerIdx;
                        r_iter     <= '0;
                        r_timeout  <= 1'b0;
                        r_initW    <= 1'b1;
                        r_initX    <= 1'b1;
                        r_loadA    <= 1'b1;
                        r_loadSel  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                INIT: r_state <= MULT;
                MULT: r_state <= ADD;
                ADD: begin
                    r_state <= WB;
                    r_loadA <= 1'b1;
                end
                WB: begin
                    r_state <= CHECK;
                    if (r_iter < ITER_W'(MAX_ITER)) begin
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                CHECK: begin
                    if (bus.is_finished) begin
                        r_state   <= DONE;
                        r_timeout <= 1'b0;
                        r_done    <= r_grant;
                    end else if (r_iter == ITER_W'(MAX_ITER)) begin
                        r_state   <= DONE;
                        r_timeout <= 1'b1;
                        r_done    <= r_grant;
                    end else begin
                        r_state <= MULT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    if (r_grantIdx == PTR_W'(N_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_grantIdx + PTR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.init_w     = r_initW;
    assign bus.init_x     = r_initX;
    assign bus.load_a     = r_loadA;
    assign bus.load_sel   = r_loadSel;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.iter_count = r_iter;

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Bench for maxnet_scheduler. The cap is set to 3 so that timeout jobs stay short.
// Stimulus queues the expected grant and the expected done record for each job.
// A monitor pops and compares them whenever the DUT presents an INIT or a done pulse.
module tb_maxnet_scheduler;

    localparam int NR = 4;
    localparam int MI = 3;
    localparam int IW = 5;

    typedef struct packed {
        logic [NR-1:0] done;
        logic          timeout;
        logic [IW-1:0] iter;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    result_t       doneQ[$];
    logic [NR-1:0] grantQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    maxnet_scheduler_if #(.N_REQ(NR), .ITER_W(IW)) bus ();

    maxnet_scheduler #(
        .N_REQ    (NR),
        .MAX_ITER (MI),
        .ITER_W   (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference strobe pattern {init_w, init_x, load_a, load_sel, busy}.
    // p is the cycle offset from INIT, and dp is the offset of the DONE cycle.
    function automatic logic [4:0] expectedStrobes(input int p, input int dp);
        int q;
        if (p == 0) return 5'b11111;
        if (p >= dp) return 5'b00001;
        q = (p - 1) % 4;
        return (q == 2) ? 5'b00101 : 5'b00001;
    endfunction

    // Scoreboard monitor. It samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst && bus.init_w) begin
            if (grantQ.size() == 0) reportFail("unexpected_grant", 32'(bus.grant), 0);
            else checkOutput("grant", 32'(bus.grant), 32'(grantQ.pop_front()));
        end
        if (rst && (bus.done != '0)) begin
            if (doneQ.size() == 0) reportFail("unexpected_done", 32'(bus.done), 0);
            else checkOutput("done_timeout_iter", 32'({bus.done, bus.timeout, bus.iter_count}),
                             32'(doneQ.pop_front()));
        end
    end

    // Runs one job.
    // finishRound: is_finished rises after that many WB pulses (0 = never).
    // rounds: the number of MULT..CHECK rounds the job should take.
    task automatic applyStimulus(input logic [NR-1:0] reqVal, input logic [NR-1:0] expGrant,
                                 input int finishRound, input int rounds, input bit expTimeout,
                                 input bit dropInAdd, input bit holdReq);
        int pos, wb, budget, donePos, badCount;
        bit seenInit, seenDone;
        logic [4:0] gotS, expS;
        donePos = 1 + 4 * rounds;
        grantQ.push_back(expGrant);
        doneQ.push_back({expGrant, expTimeout, IW'(rounds)});
        bus.req = reqVal;
        bus.is_finished = 1'b0;
        seenInit = 0;
        budget = 0;
        while (!seenInit && budget < 20) begin
            @(negedge clk);
            budget++;
            if (bus.init_w) seenInit = 1;
        end
        if (!seenInit) begin
            reportFail("init_wait", 0, 1);
            bus.req = '0;
            return;
        end
        pos = 0;
        wb = 0;
        badCount = 0;
        seenDone = 0;
        while (!seenDone && pos < 100) begin
            expS = expectedStrobes(pos, donePos);
            gotS = {bus.init_w, bus.init_x, bus.load_a, bus.load_sel, bus.busy};
            if (gotS !== expS) begin
                badCount++;
                $display("[TB] strobe cycle %0d got %b want %b", pos, gotS, expS);
            end
            if (bus.load_a && !bus.load_sel) begin
                wb++;
                if (wb == finishRound) bus.is_finished = 1'b1;
            end
            if (dropInAdd && pos == 2) bus.req = '0;
            if (bus.done != '0) seenDone = 1;
            else begin
                @(negedge clk);
                pos++;
            end
        end
        checkOutput("strobe_errors", 32'(badCount), 0);
        if (seenDone) checkOutput("latency", 32'(pos + 1), 32'(donePos + 1));
        else reportFail("done_wait", 32'(pos), 32'(donePos));
        checkOutput("wb_pulses", 32'(wb), 32'(rounds));
        bus.is_finished = 1'b0;
        @(negedge clk);
        checkOutput("idle_gap", 32'({bus.busy, bus.grant}), 0);
        if (!holdReq) bus.req = '0;
    endtask

    // Aborts a job for requester 2 by asserting reset in its first CHECK.
    task automatic applyResetMidJob();
        int budget;
        bit seenWb;
        grantQ.push_back(4'b0100);
        bus.req = 4'b0100;
        bus.is_finished = 1'b0;
        seenWb = 0;
        budget = 0;
        while (!seenWb && budget < 20) begin
            @(negedge clk);
            budget++;
            if (bus.load_a && !bus.load_sel) seenWb = 1;
        end
        if (!seenWb) reportFail("wb_wait", 0, 1);
        bus.req = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    32'({bus.grant, bus.done, bus.init_w, bus.init_x, bus.load_a,
                         bus.load_sel, bus.busy, bus.timeout, bus.iter_count}), 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_held_outputs", 32'({bus.grant, bus.done, bus.busy, bus.iter_count}), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Guard against a hung DUT.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed job sequence. The rr pointer is traced in the comments after each job.
    initial begin
        bus.req = '0;
        bus.is_finished = 1'b0;
        @(negedge clk);
        checkOutput("reset_state",
                    32'({bus.grant, bus.done, bus.init_w, bus.init_x, bus.load_a,
                         bus.load_sel, bus.busy, bus.timeout, bus.iter_count}), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        applyStimulus(4'b0001, 4'b0001, 1, 1, 1'b0, 1'b0, 1'b0); // ptr -> 1
        applyStimulus(4'b0010, 4'b0010, 0, 3, 1'b1, 1'b0, 1'b0); // cap hit, ptr -> 2
        applyStimulus(4'b0100, 4'b0100, 2, 2, 1'b0, 1'b0, 1'b0); // ptr -> 3
        applyStimulus(4'b0101, 4'b0001, 1, 1, 1'b0, 1'b0, 1'b1); // wrap, ptr -> 1
        applyStimulus(4'b0101, 4'b0100, 1, 1, 1'b0, 1'b0, 1'b0); // ptr -> 3
        applyStimulus(4'b0010, 4'b0010, 1, 1, 1'b0, 1'b1, 1'b0); // drop in ADD, ptr -> 2
        applyStimulus(4'b0011, 4'b0001, 1, 1, 1'b0, 1'b0, 1'b0); // ptr -> 1
        applyStimulus(4'b0010, 4'b0010, 3, 3, 1'b0, 1'b0, 1'b0); // finish and cap together
        applyResetMidJob();                                       // ptr -> 0

        applyStimulus(4'b1111, 4'b0001, 1, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b0010, 1, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b0100, 1, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b1000, 1, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b0001, 1, 1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("grant_queue_empty", 32'(grantQ.size()), 0);
        checkOutput("done_queue_empty", 32'(doneQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
